hazard_fwd_ctrl: RTL

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl_pkg.sv | 23 ++
 rtl/hazard_fwd_ctrl_if.sv | 33 +++
 rtl/hazard_fwd_ctrl_fwd_match.sv | 21 ++
 rtl/hazard_fwd_ctrl.sv | 83 ++++++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the hazard / forwarding controller: operand-select encoding
// and the tag-pipeline entry that shadows each EX/MEM/WB instruction.
package hazard_fwd_ctrl_pkg;

  // Specifier fields are stored at this width; REG_W of any instance must not exceed it.
  localparam int unsigned REG_W_MAX = 8;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic                 is_load;
    logic                 rs_used;
    logic                 rt_used;
    logic [REG_W_MAX-1:0] wr_reg;
    logic [REG_W_MAX-1:0] rs;
    logic [REG_W_MAX-1:0] rt;
  } tag_entry_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage instruction description, pipeline control inputs and the
// stall / forwarding decisions returned to the datapath.
interface hazard_fwd_ctrl_if #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             id_wr_en;
  logic [REG_W-1:0] id_wr_reg;
  logic             id_is_load;
  logic             mem_busy;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_rs_sel;
  logic [1:0]       fwd_rt_sel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wr_en, id_wr_reg, id_is_load, mem_busy, flush,
    input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wr_en, id_wr_reg, id_is_load, mem_busy, flush,
    output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
// fwd_match: does a tag entry write register `spec`? Register 0 is hard-wired
// and never matches when ZERO_REG_FIXED is set.
module hazard_fwd_ctrl_fwd_match
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_W          = 3,
  parameter bit          ZERO_REG_FIXED = 1'b1
) (
  input  tag_entry_t       entry,
  input  logic [REG_W-1:0] spec,
  output logic             writes
);
  logic [REG_W_MAX-1:0] spec_x;
  logic                 unused_fields;

  assign spec_x = REG_W_MAX'(spec);
  assign writes = entry.valid & entry.wr_en & (entry.wr_reg == spec_x)
                & ~(ZERO_REG_FIXED & (spec == '0));

  assign unused_fields = ^{entry.is_load, entry.rs_used, entry.rt_used, entry.rs, entry.rt};
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall detection and EX operand forwarding, driven by a private
// three-stage tag pipeline (EX, MEM, WB) that mirrors the datapath.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_W          = 3,
  parameter bit          ZERO_REG_FIXED = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_fwd_ctrl_if.slave   bus
);
  tag_entry_t       ex_q, mem_q, wb_q, id_entry;
  logic [CNT_W-1:0] cnt_q;
  logic             stall_c;
  logic             mem_wr_rs, mem_wr_rt, wb_wr_rs, wb_wr_rt;
  logic             ex_wr_id_rs, ex_wr_id_rt;
  logic             unused_fields;

  hazard_fwd_ctrl_fwd_match #(.REG_W(REG_W), .ZERO_REG_FIXED(ZERO_REG_FIXED)) u_mem_rs (
    .entry(mem_q), .spec(REG_W'(ex_q.rs)), .writes(mem_wr_rs));
  hazard_fwd_ctrl_fwd_match #(.REG_W(REG_W), .ZERO_REG_FIXED(ZERO_REG_FIXED)) u_mem_rt (
    .entry(mem_q), .spec(REG_W'(ex_q.rt)), .writes(mem_wr_rt));
  hazard_fwd_ctrl_fwd_match #(.REG_W(REG_W), .ZERO_REG_FIXED(ZERO_REG_FIXED)) u_wb_rs (
    .entry(wb_q), .spec(REG_W'(ex_q.rs)), .writes(wb_wr_rs));
  hazard_fwd_ctrl_fwd_match #(.REG_W(REG_W), .ZERO_REG_FIXED(ZERO_REG_FIXED)) u_wb_rt (
    .entry(wb_q), .spec(REG_W'(ex_q.rt)), .writes(wb_wr_rt));
  hazard_fwd_ctrl_fwd_match #(.REG_W(REG_W), .ZERO_REG_FIXED(ZERO_REG_FIXED)) u_ex_id_rs (
    .entry(ex_q), .spec(bus.id_rs), .writes(ex_wr_id_rs));
  hazard_fwd_ctrl_fwd_match #(.REG_W(REG_W), .ZERO_REG_FIXED(ZERO_REG_FIXED)) u_ex_id_rt (
    .entry(ex_q), .spec(bus.id_rt), .writes(ex_wr_id_rt));

  // Load in EX feeding a source the ID instruction reads; a flush cancels it.
  assign stall_c = bus.id_valid & ~bus.flush & ex_q.is_load
                 & ((bus.id_rs_used & ex_wr_id_rs) | (bus.id_rt_used & ex_wr_id_rt));

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = bus.id_valid & ~stall_c & ~bus.flush;
    id_entry.wr_en   = bus.id_wr_en;
    id_entry.is_load = bus.id_is_load;
    id_entry.rs_used = bus.id_rs_used;
    id_entry.rt_used = bus.id_rt_used;
    id_entry.wr_reg  = REG_W_MAX'(bus.id_wr_reg);
    id_entry.rs      = REG_W_MAX'(bus.id_rs);
    id_entry.rt      = REG_W_MAX'(bus.id_rt);
  end

  // Youngest producer (MEM) wins over WB.
  always_comb begin
    bus.fwd_rs_sel = FWD_RF;
    bus.fwd_rt_sel = FWD_RF;
    if (ex_q.valid && ex_q.rs_used) begin
      if (mem_wr_rs)     bus.fwd_rs_sel = FWD_EXMEM;
      else if (wb_wr_rs) bus.fwd_rs_sel = FWD_MEMWB;
    end
    if (ex_q.valid && ex_q.rt_used) begin
      if (mem_wr_rt)     bus.fwd_rt_sel = FWD_EXMEM;
      else if (wb_wr_rt) bus.fwd_rt_sel = FWD_MEMWB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (!bus.mem_busy) begin
      ex_q  <= id_entry;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall     = stall_c;
  assign bus.stall_cnt = cnt_q;

  assign unused_fields = ^{mem_q.is_load, mem_q.rs_used, mem_q.rt_used, mem_q.rs, mem_q.rt,
                           wb_q.is_load, wb_q.rs_used, wb_q.rt_used, wb_q.rs, wb_q.rt};
endmodule
